// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready load channel carrying a 16-bit display value and 4 decimal points
//   load_valid  producer offers load_value/load_dp
//   load_ready  controller pending slot is empty
//   load_value  display value, nibble i -> digit i
//   load_dp     decimal point per digit
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  modport master(output load_valid, load_value, load_dp, input load_ready);
  modport slave(input load_valid, load_value, load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed seven-segment scan controller with frame-aligned value loads
//   clk, reset  clock and asynchronous active-high reset
//   load        seg_scan_ctrl_if.slave load channel (value + decimal points)
//   blank_mask  1 forces digit i dark, sampled every cycle
//   hex_out     nibble for the current digit, dp_out its decimal point
//   enable      active-low digit enables
//   frame_done  pulse on the last cycle of every frame
//   Define LEADING_ZERO_BLANK_EN to also darken leading zero digits 1..3.
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 65536,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_ctrl_if.slave   load,
  input  logic [3:0]       blank_mask,
  output logic [3:0]       hex_out,
  output logic             dp_out,
  output logic [3:0]       enable,
  output logic             frame_done
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] LIT = 1'b1;
  logic [0:0]    state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_n;
  logic [15:0]   shadow, pend, shadow_n;
  logic [3:0]    sdp, pdp, sdp_n;
  logic          full, last, take, apply, step;
  logic [3:0]    dark, en_n;
  assign last = cnt == (state == LIT ? DWELL_LAST : BLANK_LAST);
  assign step = last && state == LIT;
  assign frame_done = step && idx == 2'd3;
  assign load.load_ready = !full;
  assign take = load.load_valid && !full;
  assign apply = frame_done && full;
  assign state_n = last ? ~state : state;
  assign idx_n = step ? idx + 2'd1 : idx;
  // the value shown from digit 0 of the next frame is the one swapped in on the boundary edge
  assign shadow_n = apply ? pend : shadow;
  assign sdp_n = apply ? pdp : sdp;
`ifdef LEADING_ZERO_BLANK_EN
  assign dark = blank_mask | {~|shadow[15:12], ~|shadow[15:8], ~|shadow[15:4], 1'b0};
`else
  assign dark = blank_mask;
`endif
  // enable is registered from next-state so reset drives it dark asynchronously
  assign en_n = state_n == LIT && !dark[idx_n] ? ~(4'b0001 << idx_n) : 4'b1111;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= '0;
      sdp     <= '0;
      pend    <= '0;
      pdp     <= '0;
      full    <= 1'b0;
      hex_out <= '0;
      dp_out  <= 1'b0;
      enable  <= 4'b1111;
    end else begin
      state  <= state_n;
      cnt    <= last ? '0 : cnt + 1'b1;
      idx    <= idx_n;
      enable <= en_n;
      shadow <= shadow_n;
      sdp    <= sdp_n;
      full   <= take || (full && !frame_done);
      if (take) begin
        pend <= load.load_value;
        pdp  <= load.load_dp;
      end
      // hex/dp only move entering BLANK so the decoder settles while digits are dark
      if (step) begin
        hex_out <= shadow_n[4*idx_n +: 4];
        dp_out  <= sdp_n[idx_n];
      end
    end
endmodule
